// File: rtl/multi_wave_display.sv
// Multi-channel oscilloscope renderer: captures NUM_CH sample streams into ping-pong
// banks and draws each channel as a waveform in its own horizontal lane.
module multi_wave_display #(
    parameter int NUM_CH       = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int LANE_H       = 120,
    parameter int TRIG_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_sample,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] sample,
    input  logic [NUM_CH-1:0]              ch_enable,
    input  logic                           trig_mode,
    input  logic                           freeze,
    input  logic [10:0]                    x,
    input  logic [9:0]                     y,
    input  logic                           valid,
    input  logic                           vsync,
    output logic [7:0]                     r,
    output logic [7:0]                     g,
    output logic [7:0]                     b,
    output logic [1:0]                     capture_state
);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } cap_state_t;

    localparam int CW       = $clog2(TRIG_TIMEOUT + 1);
    localparam int CENTER   = LANE_H / 2;
    localparam int AMP_LIM  = CENTER - 1;

    // ------------------------------------------------------------------
    // Capture control
    // ------------------------------------------------------------------
    cap_state_t      state, state_n;
    logic            wbank, wbank_n;
    logic            rd_valid, rd_valid_n;
    logic [7:0]      wr_addr, wr_addr_n;
    logic [CW-1:0]   tcount, tcount_n;
    logic            prev_msb;
    logic            vs_d;
    logic            we;
    logic            ch0_msb;
    logic            vs_rise;

    assign ch0_msb = sample[SAMPLE_WIDTH-1];
    assign vs_rise = vsync & ~vs_d;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        wbank_n    = wbank;
        rd_valid_n = rd_valid;
        wr_addr_n  = wr_addr;
        tcount_n   = tcount;
        we         = 1'b0;
        case (state)
            ARMED: begin
                if (new_sample) begin
                    if (!trig_mode || (prev_msb && !ch0_msb) ||
                        (tcount == CW'(TRIG_TIMEOUT - 1))) begin
                        we        = 1'b1;
                        wr_addr_n = 8'd1;
                        tcount_n  = '0;
                        state_n   = FILLING;
                    end else begin
                        tcount_n = tcount + 1'b1;
                    end
                end
            end
            FILLING: begin
                if (new_sample) begin
                    we        = 1'b1;
                    wr_addr_n = wr_addr + 8'd1;
                    if (wr_addr == 8'hFF) state_n = FULL;
                end
            end
            FULL: begin
                // Samples arriving here are dropped; only a vsync edge moves on.
                if (vs_rise && !freeze) begin
                    wbank_n    = ~wbank;
                    rd_valid_n = 1'b1;
                    wr_addr_n  = 8'd0;
                    state_n    = ARMED;
                end
            end
            default: state_n = ARMED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARMED;
            wbank    <= 1'b0;
            rd_valid <= 1'b0;
            wr_addr  <= 8'd0;
            tcount   <= '0;
            prev_msb <= 1'b0;
            vs_d     <= 1'b0;
        end else begin
            state    <= state_n;
            wbank    <= wbank_n;
            rd_valid <= rd_valid_n;
            wr_addr  <= wr_addr_n;
            tcount   <= tcount_n;
            vs_d     <= vsync;
            if (new_sample) prev_msb <= ch0_msb;
        end
    end

    assign capture_state = state;

    // ------------------------------------------------------------------
    // Sample storage: [channel][bank][address]
    // ------------------------------------------------------------------
    logic [SAMPLE_WIDTH-1:0] mem [NUM_CH][2][256];

    // NOTE: the RAM is deliberately not reset; rd_valid=0 hides stale contents instead.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NUM_CH; k++)
                mem[k][wbank][wr_addr] <= sample[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: lane/row decode and RAM read
    // ------------------------------------------------------------------
    logic [1:0] lane;
    logic [9:0] row;
    logic       in_region;
    logic [7:0] rd_addr;

    always_comb begin
        lane = 2'd0;
        for (int k = 1; k < NUM_CH; k++)
            if (y >= 10'(k * LANE_H)) lane = 2'(k);
        row       = y - 10'(int'(lane) * LANE_H);
        in_region = valid && (x < 11'd512) && (y < 10'(NUM_CH * LANE_H));
        rd_addr   = x[8:1];
    end

    logic                    s1_in, s1_sep, s1_a0, s1_show;
    logic [1:0]              s1_lane;
    logic [9:0]              s1_row;
    logic [SAMPLE_WIDTH-1:0] s1_cur, s1_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_in   <= 1'b0;
            s1_sep  <= 1'b0;
            s1_a0   <= 1'b0;
            s1_show <= 1'b0;
            s1_lane <= 2'd0;
            s1_row  <= 10'd0;
        end else begin
            s1_in   <= in_region;
            s1_sep  <= (row == 10'd0) && (lane != 2'd0);
            s1_a0   <= (rd_addr == 8'd0);
            s1_show <= rd_valid && ch_enable[lane];
            s1_lane <= lane;
            s1_row  <= row;
        end
        s1_cur  <= mem[lane][~wbank][rd_addr];
        s1_prev <= mem[lane][~wbank][rd_addr - 8'd1];
    end

    // ------------------------------------------------------------------
    // Stage 2: hit test and colour register
    // ------------------------------------------------------------------
    function automatic logic [9:0] trace_row(input logic [SAMPLE_WIDTH-1:0] s);
        logic signed [6:0] a;
        int                amp;
        a   = s[SAMPLE_WIDTH-1 -: 7];
        amp = int'(a);
        if (amp > AMP_LIM)       amp = AMP_LIM;
        else if (amp < -AMP_LIM) amp = -AMP_LIM;
        return 10'(CENTER - amp);
    endfunction

    logic [9:0]  t_cur, t_prev, t_lo, t_hi;
    logic        hit;
    logic [23:0] palette, pix_n;

    always_comb begin
        t_cur  = trace_row(s1_cur);
        t_prev = trace_row(s1_prev);
        t_lo   = (t_cur < t_prev) ? t_cur : t_prev;
        t_hi   = (t_cur < t_prev) ? t_prev : t_cur;
        // Spanning t(a-1)..t(a) joins steep edges into a continuous trace.
        hit    = s1_a0 ? (s1_row == t_cur) : ((s1_row >= t_lo) && (s1_row <= t_hi));
        case (s1_lane)
            2'd0:    palette = 24'hFFFF00;
            2'd1:    palette = 24'h00FFFF;
            2'd2:    palette = 24'hFF00FF;
            default: palette = 24'h00FF00;
        endcase
        pix_n = 24'h000000;
        if (s1_in) begin
            if (s1_sep)               pix_n = 24'h404040;
            else if (hit && s1_show)  pix_n = palette;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) {r, g, b} <= 24'h000000;
        else       {r, g, b} <= pix_n;
    end

endmodule

// File: tb/tb_multi_wave_display.sv
// Self-checking bench for multi_wave_display: cycle-level reference model plus
// directed capture/render scenarios with hand-computed pixel expectations.
module tb_multi_wave_display;

    localparam int NUM_CH = 4;
    localparam int SW     = 16;
    localparam int LANE_H = 120;
    localparam int TO     = 1024;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   new_sample = 1'b0;
    logic [NUM_CH*SW-1:0]   sample = '0;
    logic [NUM_CH-1:0]      ch_enable = '0;
    logic                   trig_mode = 1'b0;
    logic                   freeze = 1'b0;
    logic [10:0]            x = '0;
    logic [9:0]             y = '0;
    logic                   valid = 1'b0;
    logic                   vsync = 1'b0;
    logic [7:0]             r, g, b;
    logic [1:0]             capture_state;

    always #5 clk = ~clk;

    multi_wave_display #(
        .NUM_CH(NUM_CH), .SAMPLE_WIDTH(SW), .LANE_H(LANE_H), .TRIG_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .new_sample(new_sample), .sample(sample),
        .ch_enable(ch_enable), .trig_mode(trig_mode), .freeze(freeze),
        .x(x), .y(y), .valid(valid), .vsync(vsync),
        .r(r), .g(g), .b(b), .capture_state(capture_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state, m_wbank, m_rdv, m_addr, m_cnt;
    bit          m_vs, m_prev;
    logic [15:0] m_bank [2][NUM_CH][256];
    logic [23:0] m_p1, m_out;

    function automatic int tr(input logic [15:0] s);
        int v, amp;
        v   = int'($signed(s));
        amp = v >>> 9;
        if (amp > 59)  amp = 59;
        if (amp < -59) amp = -59;
        return 60 - amp;
    endfunction

    function automatic logic [23:0] model_pix(input int px, input int py, input bit pv,
                                              input logic [3:0] en);
        int lane, row, a, t0, t1;
        bit hit;
        if (!pv || px >= 512 || py >= NUM_CH * LANE_H) return 24'h0;
        lane = py / LANE_H;
        row  = py % LANE_H;
        if (row == 0 && lane > 0) return 24'h404040;
        if (m_rdv == 0 || !en[lane]) return 24'h0;
        a  = px / 2;
        t0 = tr(m_bank[1 - m_wbank][lane][a]);
        if (a == 0) hit = (row == t0);
        else begin
            t1  = tr(m_bank[1 - m_wbank][lane][a - 1]);
            hit = (row >= ((t0 < t1) ? t0 : t1)) && (row <= ((t0 < t1) ? t1 : t0));
        end
        if (!hit) return 24'h0;
        case (lane)
            0:       return 24'hFFFF00;
            1:       return 24'h00FFFF;
            2:       return 24'hFF00FF;
            default: return 24'h00FF00;
        endcase
    endfunction

    task automatic m_write(input int addr);
        for (int k = 0; k < NUM_CH; k++) m_bank[m_wbank][k][addr] = sample[k*SW +: SW];
    endtask

    always @(posedge clk) begin
        bit rise, msb;
        if (reset) begin
            m_state = 0; m_wbank = 0; m_rdv = 0; m_addr = 0; m_cnt = 0;
            m_vs = 1'b0; m_prev = 1'b0; m_p1 = '0; m_out = '0;
        end else begin
            m_out = m_p1;
            m_p1  = model_pix(int'(x), int'(y), valid, ch_enable);
            rise  = vsync && !m_vs;
            m_vs  = vsync;
            msb   = sample[SW-1];
            case (m_state)
                0: if (new_sample) begin
                    m_cnt++;
                    if (!trig_mode || (m_prev && !msb) || m_cnt == TO) begin
                        m_write(0);
                        m_addr = 1; m_cnt = 0; m_state = 1;
                    end
                end
                1: if (new_sample) begin
                    m_write(m_addr);
                    if (m_addr == 255) begin m_addr = 0; m_state = 2; end
                    else m_addr++;
                end
                default: if (rise && !freeze) begin
                    m_wbank = 1 - m_wbank; m_rdv = 1; m_addr = 0; m_state = 0;
                end
            endcase
            if (new_sample) m_prev = msb;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_rgb", {8'h0, r, g, b}, {8'h0, m_out});
            check("model_state", {30'h0, capture_state}, m_state);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input logic [15:0] c0, c1, c2, c3);
        sample     = {c3, c2, c1, c0};
        new_sample = 1'b1;
        @(negedge clk);
        new_sample = 1'b0;
        @(negedge clk);
    endtask

    task automatic vpulse();
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pix(input int px, input int py, input logic [23:0] exp, input string nm);
        x = 11'(px); y = 10'(py); valid = 1'b1;
        repeat (2) @(negedge clk);
        check(nm, {8'h0, r, g, b}, {8'h0, exp});
        valid = 1'b0;
    endtask

    task automatic scan();
        for (int yy = 0; yy < 480; yy += 13)
            for (int xx = 0; xx < 8; xx++) begin
                x = 11'(xx); y = 10'(yy); valid = 1'b1;
                @(negedge clk);
            end
        x = 11'd700; y = 10'd60;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_state", {30'h0, capture_state}, 32'd0);
        check("reset_rgb", {8'h0, r, g, b}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Free-run capture: ch0 = k<<9 gives amp(k)=k for small k.
        trig_mode = 1'b0; ch_enable = 4'b0001;
        for (int k = 0; k < 256; k++) begin
            strobe(16'(k << 9), 16'h0, 16'h0, 16'h0);
            if (k == 0) check("fr_filling", {30'h0, capture_state}, 32'd1);
        end
        check("fr_full", {30'h0, capture_state}, 32'd2);
        pix(0, 60, 24'h000000, "no_trace_before_swap");
        vpulse();
        check("fr_armed", {30'h0, capture_state}, 32'd0);
        pix(2, 59, 24'hFFFF00, "fr_t1");
        pix(2, 60, 24'hFFFF00, "fr_connect_t0");
        pix(2, 58, 24'h000000, "fr_above");
        pix(0, 59, 24'h000000, "fr_a0_only");
        pix(0, 60, 24'hFFFF00, "fr_a0_t0");
        scan();

        // Lane colouring: all channels at zero.
        for (int k = 0; k < 256; k++) strobe(16'h0, 16'h0, 16'h0, 16'h0);
        vpulse();
        ch_enable = 4'b0101;
        pix(10, 60,  24'hFFFF00, "lane0_on");
        pix(10, 180, 24'h000000, "lane1_off");
        pix(10, 300, 24'hFF00FF, "lane2_on");
        pix(10, 420, 24'h000000, "lane3_off");
        pix(10, 120, 24'h404040, "sep1");
        pix(10, 240, 24'h404040, "sep2");
        pix(10, 360, 24'h404040, "sep3");
        pix(10, 0,   24'h000000, "lane0_row0");
        pix(511, 60, 24'hFFFF00, "x511");
        pix(512, 60, 24'h000000, "x512");
        pix(600, 60, 24'h000000, "x600");
        scan();

        // Clamp and connect on ch1.
        ch_enable = 4'b0010;
        strobe(16'h0, 16'h7FFF, 16'h0, 16'h0);
        strobe(16'h0, 16'h8000, 16'h0, 16'h0);
        for (int k = 0; k < 254; k++) strobe(16'h0, 16'h0, 16'h0, 16'h0);
        vpulse();
        pix(2, 121, 24'h00FFFF, "clamp_row1");
        pix(2, 239, 24'h00FFFF, "clamp_row119");
        pix(3, 180, 24'h00FFFF, "clamp_x3");
        pix(2, 120, 24'h404040, "clamp_sep");
        pix(0, 121, 24'h00FFFF, "clamp_a0_top");
        pix(0, 122, 24'h000000, "clamp_a0_only");
        pix(4, 180, 24'h00FFFF, "clamp_a2_lit");
        pix(4, 170, 24'h000000, "clamp_a2_dark");
        scan();

        // Trigger on rising zero-cross of ch0.
        trig_mode = 1'b1; ch_enable = 4'b0001;
        strobe(16'hFF9C, 16'h0, 16'h0, 16'h0);
        check("trig_wait1", {30'h0, capture_state}, 32'd0);
        strobe(16'hFFCE, 16'h0, 16'h0, 16'h0);
        check("trig_wait2", {30'h0, capture_state}, 32'd0);
        strobe(16'h0014, 16'h0, 16'h0, 16'h0);
        check("trig_fire", {30'h0, capture_state}, 32'd1);
        for (int k = 0; k < 255; k++) strobe(16'h4000, 16'h0, 16'h0, 16'h0);
        check("trig_full", {30'h0, capture_state}, 32'd2);
        vpulse();
        pix(0, 60, 24'hFFFF00, "trig_addr0");
        pix(0, 61, 24'h000000, "trig_not_m50");
        pix(0, 28, 24'h000000, "trig_a0_only");
        pix(2, 28, 24'hFFFF00, "trig_a1");

        // Timeout: no crossing, forced capture on the 1024th sample.
        for (int k = 0; k < TO - 1; k++) strobe(16'd5, 16'd5, 16'd5, 16'd5);
        check("no_trig", {30'h0, capture_state}, 32'd0);
        strobe(16'd5, 16'd5, 16'd5, 16'd5);
        check("timeout_fill", {30'h0, capture_state}, 32'd1);

        // Freeze raised mid-fill; fill completes and waits in FULL.
        for (int k = 0; k < 100; k++) strobe(16'd5, 16'd5, 16'd5, 16'd5);
        freeze = 1'b1;
        for (int k = 0; k < 155; k++) strobe(16'd5, 16'd5, 16'd5, 16'd5);
        check("freeze_full", {30'h0, capture_state}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            vpulse();
            strobe(16'h4000, 16'h4000, 16'h4000, 16'h4000);
            check("frozen_state", {30'h0, capture_state}, 32'd2);
        end
        pix(2, 28, 24'hFFFF00, "frozen_old_bank");
        freeze = 1'b0;
        repeat (2) @(negedge clk);
        check("unfrozen_wait", {30'h0, capture_state}, 32'd2);
        vpulse();
        check("unfreeze_swap", {30'h0, capture_state}, 32'd0);
        pix(2, 28, 24'h000000, "new_bank_old_gone");
        pix(2, 60, 24'hFFFF00, "new_bank_trace");
        pix(10, 28, 24'h000000, "drop_in_full");

        // Reset mid-fill.
        trig_mode = 1'b0;
        x = 11'd10; y = 10'd60; valid = 1'b1;
        for (int k = 0; k < 100; k++) strobe(16'h0, 16'h0, 16'h0, 16'h0);
        check("pre_reset_lit", {8'h0, r, g, b}, 32'hFFFF00);
        reset = 1'b1;
        @(negedge clk);
        check("rst_state", {30'h0, capture_state}, 32'd0);
        check("rst_rgb", {8'h0, r, g, b}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_trace", {8'h0, r, g, b}, 32'h0);
        valid = 1'b0;
        for (int k = 0; k < 256; k++) strobe(16'h0, 16'h0, 16'h0, 16'h0);
        pix(10, 60, 24'h000000, "rst_still_dark");
        vpulse();
        pix(10, 60, 24'hFFFF00, "rst_trace_back");
        scan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
